booth_r4_seq_ctrl: RTL and testbench



---
 rtl/booth_pkg.sv | 39 +++
 rtl/booth_r4_ppgen.sv | 33 +++
 rtl/carry_lookahead_adder.sv | 52 +++++
 rtl/booth_r4_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_booth_r4_seq_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

  // Group count for the default 32-bit operand width.
  // The top derives its own group count from its N parameter.
  localparam int N_DEFAULT = 32;
  localparam int NGROUPS   = N_DEFAULT / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial-product selection for one recoding group.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PB   = 3'd1,
    P2B  = 3'd2,
    M2B  = 3'd3,
    MB   = 3'd4
  } booth_op_e;

  // Map {a[2j+1], a[2j], a[2j-1]} to the partial-product operation.
  function automatic booth_op_e booth_decode(input logic [2:0] grp);
    booth_op_e op;
    case (grp)
      3'b001, 3'b010: op = PB;
      3'b011:         op = P2B;
      3'b100:         op = M2B;
      3'b101, 3'b110: op = MB;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// Radix-4 Booth partial-product generator: selects 0, +-B or +-2B at 2N bits (unshifted).
// Latency: combinational.
// Backpressure: n/a.
module booth_r4_ppgen
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]     grp,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] pp
);

  logic [2*N-1:0] bx;
  logic [2*N-1:0] b2x;

  // Sign-extend first so doubling and negation are exact at 2N bits.
  assign bx  = {{N{b[N-1]}}, b};
  assign b2x = {bx[2*N-2:0], 1'b0};

  // Select the partial product for this group's recoding.
  always_comb begin
    pp = '0;
    case (booth_decode(grp))
      PB:      pp = bx;
      P2B:     pp = b2x;
      M2B:     pp = -b2x;
      MB:      pp = -bx;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/carry_lookahead_adder.sv
// W-bit adder: 4-bit lookahead blocks joined by a block-carry chain; carry-out dropped.
// Latency: combinational.
// Backpressure: n/a.
module carry_lookahead_adder #(
  parameter int W = 64  // must be a multiple of 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam int NB = W / 4;

  logic [W-1:0]  p;
  logic [W-1:0]  g;
  logic [W-1:0]  c;
  logic [NB-1:0] bg;
  logic [NB-1:0] bp;
  logic [NB-1:0] cb;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int L = 4 * k;

    // Block generate/propagate for the inter-block chain.
    assign bg[k] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                 | (p[L+3] & p[L+2] & p[L+1] & g[L]);
    assign bp[k] = &p[L+3:L];

    // In-block carries are fully expanded from the block carry-in.
    assign c[L]   = cb[k];
    assign c[L+1] = g[L] | (p[L] & cb[k]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & cb[k]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & cb[k]);
  end

  // Block carry chain; the carry out of the top block is discarded.
  always_comb begin
    logic cy;
    cy = 1'b0;
    for (int k = 0; k < NB; k++) begin
      cb[k] = cy;
      cy    = bg[k] | (bp[k] & cy);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential signed NxN radix-4 Booth multiplier: one recoding group per clock.
// Latency: accept edge t0 -> out_valid after edge t0+N/2; initiation interval N/2+2.
// Backpressure: product and out_valid held in DONE until out_ready; in_ready low outside IDLE.
module booth_r4_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N  = 32,  // even, >= 4
  parameter int CW = 5    // 2**CW > N/2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*N-1:0] product,
  output logic          busy,
  output logic [CW-1:0] iter
);

  localparam int            W         = 2 * N;
  localparam logic [CW-1:0] LAST_ITER = CW'(N / 2 - 1);

  state_e         state;
  state_e         state_nxt;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [W-1:0]   acc;
  logic [CW-1:0]  iter_r;
  logic [N:0]     a_ext;
  logic [2:0]     grp;
  logic [W-1:0]   pp;
  logic [W-1:0]   pp_sh;
  logic [W-1:0]   acc_sum;

  // Implicit zero below bit 0 so group 0 sees {a[1], a[0], 0}.
  assign a_ext = {a_r, 1'b0};
  assign grp   = a_ext[{iter_r, 1'b0} +: 3];

  booth_r4_ppgen #(.N(N)) u_ppgen (
    .grp (grp),
    .b   (b_r),
    .pp  (pp)
  );

  assign pp_sh = pp << {iter_r, 1'b0};

  carry_lookahead_adder #(.W(W)) u_add (
    .a   (acc),
    .b   (pp_sh),
    .sum (acc_sum)
  );

  // State register; reset wins over both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (iter_r == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand capture, accumulation and group counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      iter_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            acc    <= '0;
            iter_r <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          // The counter parks on the last group so it stays visible in DONE.
          if (iter_r != LAST_ITER) iter_r <= iter_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The accumulator is the product; out_valid alone qualifies it.
  assign product = acc;
  assign iter    = iter_r;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Testbench for booth_r4_seq_ctrl: vector table, hand sequences and random regression.
// Latency: checks N/2 cycles from accept to out_valid.
// Backpressure: random out_ready stalls with stability checks.
module tb_booth_r4_seq_ctrl;

  localparam int N  = 32;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [2*N-1:0]  product;
  logic            busy;
  logic [CW-1:0]   iter;

  always #5 clk = ~clk;

  booth_r4_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .iter      (iter)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_in = 0;
  int          n_out = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  // One full transaction: request, run, optional stall, handshake.
  task automatic do_mul(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [63:0] texp, input int stall, input bit lat);
    int          cyc;
    logic [63:0] held;
    logic [63:0] e;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    check("in_ready_before_req", 64'(in_ready), 64'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_q.push_back(texp);
    n_in++;
    // Operands moving during RUN must not matter.
    a = $urandom;
    b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      check("busy_run", 64'(busy), 64'd1);
      check("in_ready_run", 64'(in_ready), 64'd0);
      step();
      cyc++;
    end
    if (lat) check("latency", 64'(cyc), 64'd16);
    if (!out_valid) begin
      check("out_valid_timeout", 64'(out_valid), 64'd1);
      return;
    end
    held = product;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      step();
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_product", product, held);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("scoreboard_size", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("product", product, e);
      n_out++;
    end
    step();
    out_ready = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int          cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    longint      sa;
    longint      sb;

    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[5] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_iter", 64'(iter), 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;
    step();

    // Table vectors; the first one also exercises a long out_ready stall.
    for (int i = 0; i < 7; i++) begin
      do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 10 : (i % 3), 1'b1);
    end

    // Reset while the counter sits on group 7.
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (iter != 5'd7 && cyc < 40) begin
      step();
      cyc++;
    end
    check("mid_iter_reached", 64'(iter), 64'd7);
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_acc", product, 64'd0);
    do_mul(32'h0000_0002, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 2, 1'b1);

    // Random signed regression with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      do_mul(ra, rb, 64'(sa * sb), $urandom_range(0, 3), 1'b0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("in_out_count", 64'(n_out), 64'(n_in));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
